// File: rtl/clock_time_controller.sv
// Timekeeping controller: 1 Hz prescaler, hh:mm:ss counters and a button-driven set-mode FSM.
// Define CLOCK_ALARM_EN to add the alarm set states and the alarm output.
module clock_time_controller #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [2:0] mode_state,
  output logic       blink,
`ifdef CLOCK_ALARM_EN
  output logic       alarm,
`endif
  output logic       tick_1hz
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  typedef logic [PW-1:0] presc_t;
  localparam presc_t PrescMax  = presc_t'(TICK_DIV - 1);
  localparam presc_t PrescHalf = presc_t'(TICK_DIV / 2);

  typedef enum logic [2:0] {
    StRun       = 3'd0,
    StSetHour   = 3'd1,
    StSetMin    = 3'd2,
    StSetAlHour = 3'd3,
    StSetAlMin  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  presc_t     presc_q, presc_d;
  logic       tick_q, tick_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  // [0],[1] synchronize the async button, [2] holds the previous level for edge detect.
  logic [2:0] mode_sync_q, inc_sync_q;
  logic       mode_ev, inc_ev, tick_w;

`ifdef CLOCK_ALARM_EN
  logic [4:0] al_hour_q, al_hour_d;
  logic [5:0] al_min_q, al_min_d;
  logic       armed_q, armed_d;
  logic       alarm_q, alarm_d;
`endif

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  assign mode_ev = mode_sync_q[1] & ~mode_sync_q[2];
  assign inc_ev  = inc_sync_q[1] & ~inc_sync_q[2];
  assign tick_w  = (presc_q == PrescMax);

  always_comb begin
    presc_d = tick_w ? '0 : presc_q + presc_t'(1);
    state_d = state_q;
    hours_d = hours_q;
    min_d   = min_q;
    sec_d   = sec_q;
`ifdef CLOCK_ALARM_EN
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    armed_d   = armed_q;
`endif
    // A mode event always wins over a coincident inc event.
    unique case (state_q)
      StRun: begin
        if (mode_ev) begin
          state_d = StSetHour;
        end else begin
          if (tick_w) begin
            sec_d = inc60(sec_q);
            if (sec_q == 6'd59) begin
              min_d = inc60(min_q);
              if (min_q == 6'd59) hours_d = inc24(hours_q);
            end
          end
`ifdef CLOCK_ALARM_EN
          if (inc_ev && alarm_q) armed_d = 1'b0;
`endif
        end
      end
      StSetHour: begin
        if (mode_ev)     state_d = StSetMin;
        else if (inc_ev) hours_d = inc24(hours_q);
      end
      StSetMin: begin
        if (mode_ev) begin
`ifdef CLOCK_ALARM_EN
          state_d = StSetAlHour;
`else
          state_d = StRun;
          sec_d   = '0;
          presc_d = '0;
`endif
        end else if (inc_ev) begin
          min_d = inc60(min_q);
        end
      end
`ifdef CLOCK_ALARM_EN
      StSetAlHour: begin
        if (mode_ev)     state_d   = StSetAlMin;
        else if (inc_ev) al_hour_d = inc24(al_hour_q);
      end
      StSetAlMin: begin
        if (mode_ev) begin
          state_d = StRun;
          sec_d   = '0;
          presc_d = '0;
          armed_d = 1'b1;
        end else if (inc_ev) begin
          al_min_d = inc60(al_min_q);
        end
      end
`endif
      default: state_d = StRun;
    endcase
    tick_d = (presc_d == PrescMax);
`ifdef CLOCK_ALARM_EN
    alarm_d = (state_d == StRun) && armed_d && (hours_d == al_hour_d) && (min_d == al_min_d);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      presc_q     <= '0;
      tick_q      <= 1'b0;
      hours_q     <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      mode_sync_q <= '0;
      inc_sync_q  <= '0;
`ifdef CLOCK_ALARM_EN
      al_hour_q   <= '0;
      al_min_q    <= '0;
      armed_q     <= 1'b0;
      alarm_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      hours_q     <= hours_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      mode_sync_q <= {mode_sync_q[1:0], btn_mode};
      inc_sync_q  <= {inc_sync_q[1:0], btn_inc};
`ifdef CLOCK_ALARM_EN
      al_hour_q   <= al_hour_d;
      al_min_q    <= al_min_d;
      armed_q     <= armed_d;
      alarm_q     <= alarm_d;
`endif
    end
  end

  assign hours      = hours_q;
  assign minutes    = min_q;
  assign seconds    = sec_q;
  assign mode_state = state_q;
  assign tick_1hz   = tick_q;
  assign blink      = (presc_q < PrescHalf);
`ifdef CLOCK_ALARM_EN
  assign alarm      = alarm_q;
`endif

endmodule
